// File: rtl/life_data_high.sv
// Upper segment of the Life cell ring plus the generation engine: rotates one cell
// per clock and, for one lap after a step request, rewrites each cell with its successor.
module life_data_high #(
    parameter int X         = 8,
    parameter int Y         = 8,
    parameter int HIGH_BITS = X + 3,
    parameter int LOG2X     = 3,
    parameter int LOG2Y     = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 step,
    input  logic                 data_low_lsb,
    output logic [HIGH_BITS-1:0] data_high,
    output logic                 data_high_lsb,
    output logic                 busy,
    output logic                 gen_done,
    output logic [15:0]          gen_count
);
    localparam int KW = LOG2X + LOG2Y;

    typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

    state_t               state_q, state_d;
    logic [KW-1:0]        k_q, k_d;
    logic [HIGH_BITS-1:0] data_high_q, data_high_d;
    logic [X:0]           lb_q, lb_d;
    logic                 gen_done_q, gen_done_d;
    logic [15:0]          gen_count_q, gen_count_d;

    logic [KW-1:0]    j;
    logic [LOG2X-1:0] xj;
    logic [LOG2Y-1:0] yj;
    logic             top_ok, bot_ok, left_ok, right_ok;
    logic [7:0]       nb;
    logic [3:0]       n;
    logic             self_c, new_c, wr;

    // Neighbourhood of target j = k-X-1, taken from the line buffer, the top of
    // this segment and the incoming cell; out-of-grid neighbours are forced dead.
    always_comb begin
        j        = k_q - KW'(X + 1);
        xj       = j[LOG2X-1:0];
        yj       = j[KW-1:LOG2X];
        top_ok   = (yj != '0);
        bot_ok   = (yj != LOG2Y'(Y - 1));
        left_ok  = (xj != '0);
        right_ok = (xj != LOG2X'(X - 1));
        self_c   = data_high_q[HIGH_BITS-X-1];
        nb[0] = lb_q[X]   & top_ok & left_ok;
        nb[1] = lb_q[X-1] & top_ok;
        nb[2] = lb_q[X-2] & top_ok & right_ok;
        nb[3] = lb_q[0]   & left_ok;
        nb[4] = data_high_q[HIGH_BITS-X] & right_ok;
        nb[5] = data_high_q[HIGH_BITS-2] & bot_ok & left_ok;
        nb[6] = data_high_q[HIGH_BITS-1] & bot_ok;
        nb[7] = data_low_lsb & bot_ok & right_ok;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + 4'(nb[i]);
        new_c = (n == 4'd3) | (self_c & (n == 4'd2));
    end

    always_comb begin
        state_d     = state_q;
        wr          = 1'b0;
        gen_done_d  = 1'b0;
        gen_count_d = gen_count_q;
        case (state_q)
            IDLE: if (step) state_d = ARM;
            ARM: begin
                if (k_q == KW'(X + 1)) begin
                    wr      = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                wr = 1'b1;
                if (k_q == KW'(X)) begin
                    state_d     = IDLE;
                    gen_done_d  = 1'b1;
                    gen_count_d = gen_count_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The line buffer keeps the old self value, so the write below never feeds back.
    always_comb begin
        k_d         = k_q + KW'(1);
        lb_d        = {lb_q[X-1:0], data_high_q[HIGH_BITS-X-1]};
        data_high_d = {data_low_lsb, data_high_q[HIGH_BITS-1:1]};
        if (wr) data_high_d[HIGH_BITS-X-2] = new_c;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            k_q         <= '0;
            data_high_q <= '0;
            lb_q        <= '0;
            gen_done_q  <= 1'b0;
            gen_count_q <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            data_high_q <= data_high_d;
            lb_q        <= lb_d;
            gen_done_q  <= gen_done_d;
            gen_count_q <= gen_count_d;
        end
    end

    assign data_high     = data_high_q;
    assign data_high_lsb = data_high_q[0];
    assign busy          = (state_q != IDLE);
    assign gen_done      = gen_done_q;
    assign gen_count     = gen_count_q;
endmodule

// File: tb/tb_life_data_high.sv
// Bench for life_data_high: closes the ring with a behavioural low segment and checks
// against a grid-level Life model plus directed literal expectations.
module tb_life_data_high;
    localparam int X    = 8;
    localparam int Y    = 8;
    localparam int N    = X * Y;
    localparam int HB   = X + 3;
    localparam int LOWB = N - HB;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          step = 1'b0;
    logic          data_low_lsb;
    logic [HB-1:0] data_high;
    logic          data_high_lsb, busy, gen_done;
    logic [15:0]   gen_count;

    logic            preload_on = 1'b0, load_low = 1'b0, chk_en = 1'b0;
    logic [N-1:0]    pat_buf = '0;
    logic [LOWB-1:0] low_q;
    int              kc;
    logic            m_busy, m_done;
    logic [15:0]     m_count;
    int              m_left;
    logic [N-1:0]    m_grid;
    int              n_checks = 0, n_errors = 0;

    always #5 clk = ~clk;

    life_data_high #(.X(X), .Y(Y), .HIGH_BITS(HB), .LOG2X(3), .LOG2Y(3)) dut (
        .clk(clk), .reset(reset), .step(step), .data_low_lsb(data_low_lsb),
        .data_high(data_high), .data_high_lsb(data_high_lsb), .busy(busy),
        .gen_done(gen_done), .gen_count(gen_count)
    );

    assign data_low_lsb = preload_on ? pat_buf[kc] : low_q[0];

    function automatic logic [N-1:0] life(input logic [N-1:0] g);
        logic [N-1:0] r;
        int cnt, nx, ny;
        r = '0;
        for (int y = 0; y < Y; y++)
            for (int x = 0; x < X; x++) begin
                cnt = 0;
                for (int dy = -1; dy <= 1; dy++)
                    for (int dx = -1; dx <= 1; dx++) begin
                        nx = x + dx;
                        ny = y + dy;
                        if ((dx != 0 || dy != 0) && nx >= 0 && nx < X && ny >= 0 && ny < Y)
                            cnt += int'(g[ny*X+nx]);
                    end
                r[y*X+x] = (cnt == 3) || (g[y*X+x] && cnt == 2);
            end
        return r;
    endfunction

    // Grid as seen through the ring: bit b of {data_high, low} holds cell (k+b) mod N.
    function automatic logic [N-1:0] ring_grid();
        logic [N-1:0] rv, g;
        rv = {data_high, low_q};
        for (int b = 0; b < N; b++) g[(kc + b) % N] = rv[b];
        return g;
    endfunction

    // Low ring segment, position counter and generation-level timing model.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            kc <= 0; low_q <= '0; m_busy <= 1'b0; m_done <= 1'b0;
            m_count <= '0; m_left <= 0; m_grid <= '0;
        end else begin
            kc     <= (kc + 1) % N;
            low_q  <= load_low ? pat_buf[LOWB-1:0] : {data_high_lsb, low_q[LOWB-1:1]};
            m_done <= 1'b0;
            if (load_low) m_grid <= pat_buf;
            if (!m_busy) begin
                if (step) begin
                    m_busy <= 1'b1;
                    m_left <= (((X + 1) - (kc + 1)) % N + N) % N + N;
                end
            end else if (m_left == 1) begin
                m_busy  <= 1'b0;
                m_done  <= 1'b1;
                m_count <= m_count + 16'd1;
                m_grid  <= life(m_grid);
            end else begin
                m_left <= m_left - 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (chk_en && reset) begin
            chk("busy", 64'(busy), 64'(m_busy));
            chk("gen_done", 64'(gen_done), 64'(m_done));
            chk("gen_count", 64'(gen_count), 64'(m_count));
            chk("lsb", 64'(data_high_lsb), 64'(data_high[0]));
            if (!m_busy) chk("ring", 64'(ring_grid()), 64'(m_grid));
        end
    endtask

    task automatic wait_done(output int t);
        t = 0;
        while (gen_done !== 1'b1 && t < 200) begin tick(); t++; end
        chk("gen_done_seen", 64'(gen_done), 64'd1);
    endtask

    task automatic wait_k(input int k);
        int t = 0;
        while (kc != k && t < 100) begin tick(); t++; end
    endtask

    task automatic start_at(input int k);
        wait_k(k);
        step = 1'b1; tick(); step = 1'b0;
    endtask

    task automatic run_gen();
        int t;
        step = 1'b1; tick(); step = 1'b0;
        wait_done(t);
    endtask

    task automatic preload(input logic [N-1:0] p);
        chk_en = 1'b0; pat_buf = p;
        wait_k(0);
        preload_on = 1'b1; load_low = 1'b1;
        repeat (N) tick();
        preload_on = 1'b0; load_low = 1'b0; chk_en = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
    endtask

    localparam logic [N-1:0] BLINK_V = 64'h0000_0008_0808_0000;
    localparam logic [N-1:0] BLINK_H = 64'h0000_0000_1C00_0000;
    localparam logic [N-1:0] BLOCK   = 64'h0060_6000_0000_0000;
    localparam logic [N-1:0] EDGE0   = 64'h0000_0000_0000_0007;
    localparam logic [N-1:0] EDGE1   = 64'h0000_0000_0000_0202;

    initial begin
        int t, t1, t2;
        // power-on reset state
        #12;
        chk("por_data_high", 64'(data_high), 64'd0);
        chk("por_busy", 64'(busy), 64'd0);
        chk("por_gen_done", 64'(gen_done), 64'd0);
        chk("por_gen_count", 64'(gen_count), 64'd0);
        @(negedge clk);
        reset = 1'b1; chk_en = 1'b1;

        // reset mid-RUN
        preload(BLINK_V);
        start_at(8);
        repeat (30) tick();
        chk("t1_busy_before", 64'(busy), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("t1_data_high", 64'(data_high), 64'd0);
        chk("t1_lsb", 64'(data_high_lsb), 64'd0);
        chk("t1_busy", 64'(busy), 64'd0);
        chk("t1_gen_done", 64'(gen_done), 64'd0);
        chk("t1_gen_count", 64'(gen_count), 64'd0);
        tick(); tick();
        reset = 1'b1;
        run_gen();
        chk("t1_zero_ring", 64'(ring_grid()), 64'd0);
        chk("t1_count", 64'(gen_count), 64'd1);

        // blinker
        preload(BLINK_V);
        run_gen();
        chk("t2_gen1", 64'(ring_grid()), 64'(BLINK_H));
        run_gen();
        chk("t2_gen2", 64'(ring_grid()), 64'(BLINK_V));
        chk("t2_count", 64'(gen_count), 64'd3);

        // still life and empty grid
        do_reset();
        chk("t3_count0", 64'(gen_count), 64'd0);
        preload(BLOCK);
        run_gen();
        chk("t3_block", 64'(ring_grid()), 64'(BLOCK));
        chk("t3_count1", 64'(gen_count), 64'd1);
        preload('0);
        run_gen();
        chk("t3_empty", 64'(ring_grid()), 64'd0);
        chk("t3_count2", 64'(gen_count), 64'd2);

        // dead edges
        preload(EDGE0);
        run_gen();
        chk("t4_gen1", 64'(ring_grid()), 64'(EDGE1));
        run_gen();
        chk("t4_gen2", 64'(ring_grid()), 64'd0);

        // timing: step at k=20
        preload(BLINK_V);
        start_at(20);
        chk("t5_busy_rise", 64'(busy), 64'd1);
        wait_done(t);
        chk("t5_cycles", 64'(t), 64'd116);
        chk("t5_done_k", 64'(kc), 64'd9);
        chk("t5_busy_at_done", 64'(busy), 64'd0);
        chk("t5_count", 64'(gen_count), 64'd5);

        // handshake: re-pulse during RUN is ignored
        start_at(8);
        repeat (20) tick();
        step = 1'b1; tick(); step = 1'b0;
        wait_done(t);
        chk("t6_pulse_count", 64'(gen_count), 64'd6);
        repeat (5) tick();
        chk("t6_idle_busy", 64'(busy), 64'd0);
        chk("t6_idle_count", 64'(gen_count), 64'd6);

        // step held high: three back-to-back generations
        step = 1'b1;
        wait_done(t);
        tick();
        wait_done(t1);
        chk("t6_gap1", 64'(t1 + 1), 64'd128);
        tick();
        wait_done(t2);
        chk("t6_gap2", 64'(t2 + 1), 64'd128);
        step = 1'b0;
        repeat (200) tick();
        chk("t6_held_count", 64'(gen_count), 64'd9);
        chk("t6_final_busy", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
